// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a handshaked data-memory FSM, store-data forwarding and MEM/WB register
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_MemRead,
  input  logic        d_MemWrite,
  input  logic        d_RegWrite,
  input  logic        d_MemtoReg,
  input  logic [3:0]  d_RegRd,
  input  logic [3:0]  d_RegRt,
  input  logic [15:0] d_RegRtVal,
  input  logic [15:0] d_alu_data,
  input  logic        wb_RegWrite,
  input  logic [3:0]  wb_RegRd,
  input  logic [15:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        q_RegWrite,
  output logic        q_MemtoReg,
  output logic [3:0]  q_RegRd,
  output logic [15:0] q_mem_data,
  output logic [15:0] q_alu_data
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
  stateT state;
  logic memop;
  logic [15:0] storeData, captured;
  always_comb begin
    memop = d_MemRead | d_MemWrite;
    storeData = (wb_RegWrite && wb_RegRd == d_RegRt && wb_RegRd != 4'd0) ? wb_data : d_RegRtVal;
    stall = (state == IDLE && memop) || state == WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'd0;
      mem_wdata  <= 16'd0;
      captured   <= 16'd0;
      q_RegWrite <= 1'b0;
      q_MemtoReg <= 1'b0;
      q_RegRd    <= 4'd0;
      q_mem_data <= 16'd0;
      q_alu_data <= 16'd0;
    end else begin
      state <= state == IDLE ? (memop ? WAIT : IDLE) : state == WAIT ? (mem_ack ? DONE : WAIT) : IDLE;
      if (state == IDLE && memop) begin
        mem_req   <= 1'b1;
        mem_we    <= d_MemWrite;
        mem_addr  <= d_alu_data;
        mem_wdata <= storeData;
      end
      if (state == WAIT && mem_ack) begin
        mem_req  <= 1'b0;
        captured <= mem_rdata;
      end
      // a stalled cycle inserts a bubble into MEM/WB while keeping its data fields
      if (stall) begin
        q_RegWrite <= 1'b0;
        q_MemtoReg <= 1'b0;
      end else begin
        q_RegWrite <= d_RegWrite;
        q_MemtoReg <= d_MemtoReg;
        q_RegRd    <= d_RegRd;
        q_alu_data <= d_alu_data;
        q_mem_data <= state == DONE ? captured : 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against an instruction-level model
module tb_mem_stage;
  logic clk = 1'b0, rst;
  logic d_MemRead, d_MemWrite, d_RegWrite, d_MemtoReg;
  logic [3:0] d_RegRd, d_RegRt, wb_RegRd, q_RegRd;
  logic [15:0] d_RegRtVal, d_alu_data, wb_data, mem_addr, mem_wdata, mem_rdata, q_mem_data, q_alu_data;
  logic wb_RegWrite, mem_req, mem_we, mem_ack, stall, q_RegWrite, q_MemtoReg;
  logic [37:0] qAll;
  logic [33:0] mAll;
  int nChecks = 0, nFails = 0;
  assign qAll = {q_RegWrite, q_MemtoReg, q_RegRd, q_mem_data, q_alu_data};
  assign mAll = {mem_req, mem_we, mem_addr, mem_wdata};
  always #5 clk = ~clk;
  mem_stage dut (
    .clk(clk), .rst(rst),
    .d_MemRead(d_MemRead), .d_MemWrite(d_MemWrite), .d_RegWrite(d_RegWrite), .d_MemtoReg(d_MemtoReg),
    .d_RegRd(d_RegRd), .d_RegRt(d_RegRt), .d_RegRtVal(d_RegRtVal), .d_alu_data(d_alu_data),
    .wb_RegWrite(wb_RegWrite), .wb_RegRd(wb_RegRd), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .q_RegWrite(q_RegWrite), .q_MemtoReg(q_MemtoReg), .q_RegRd(q_RegRd),
    .q_mem_data(q_mem_data), .q_alu_data(q_alu_data)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clearInputs;
    {d_MemRead, d_MemWrite, d_RegWrite, d_MemtoReg} = 4'b0;
    {d_RegRd, d_RegRt, d_RegRtVal, d_alu_data} = '0;
    {wb_RegWrite, wb_RegRd, wb_data} = '0;
    {mem_ack, mem_rdata} = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    clearInputs;
    tick;
    tick;
    nChecks++;
    if (mAll !== 34'd0) begin nFails++; $display("FAIL reset_mem got %h want %h", mAll, 34'd0); end
    nChecks++;
    if (qAll !== 38'd0) begin nFails++; $display("FAIL reset_q got %h want %h", qAll, 38'd0); end
    rst = 1'b0;
    #1;
    nChecks++;
    if (stall !== 1'b0) begin nFails++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask
  task automatic test_alu;
    d_RegWrite = 1'b1;
    d_RegRd = 4'd5;
    d_alu_data = 16'h1234;
    #1;
    nChecks++;
    if (stall !== 1'b0) begin nFails++; $display("FAIL alu_stall got %b want 0", stall); end
    tick;
    nChecks++;
    if (qAll !== {1'b1, 1'b0, 4'd5, 16'h0000, 16'h1234})
      begin nFails++; $display("FAIL alu_q got %h want %h", qAll, {1'b1, 1'b0, 4'd5, 16'h0000, 16'h1234}); end
    nChecks++;
    if (mem_req !== 1'b0) begin nFails++; $display("FAIL alu_mem_req got %b want 0", mem_req); end
    clearInputs;
  endtask
  task automatic run_load(input int ackAt, input logic [15:0] addr, input logic [15:0] rdata,
                          input int wantStall, input string tag);
    int sc, rc;
    sc = 0;
    rc = 0;
    d_MemRead = 1'b1;
    d_MemtoReg = 1'b1;
    d_RegWrite = 1'b1;
    d_RegRd = 4'd7;
    d_alu_data = addr;
    for (int c = 0; c < 10; c++) begin
      #1;
      sc += int'(stall);
      rc += int'(mem_req);
      if (mem_req) begin
        nChecks++;
        if (q_RegWrite !== 1'b0) begin nFails++; $display("FAIL %s_bubble got %b want 0", tag, q_RegWrite); end
        nChecks++;
        if (mAll !== {1'b1, 1'b0, addr, 16'h0000}) begin nFails++; $display("FAIL %s_req got %h want %h", tag, mAll, {1'b1, 1'b0, addr, 16'h0000}); end
      end
      mem_ack = (rc == ackAt);
      mem_rdata = rdata;
      tick;
      mem_ack = 1'b0;
      if (!stall) break;
    end
    nChecks++;
    if (sc !== wantStall) begin nFails++; $display("FAIL %s_stall_cycles got %0d want %0d", tag, sc, wantStall); end
    nChecks++;
    if (rc !== ackAt) begin nFails++; $display("FAIL %s_req_cycles got %0d want %0d", tag, rc, ackAt); end
    nChecks++;
    if ({stall, mem_req, q_RegWrite} !== 3'b000) begin nFails++; $display("FAIL %s_done got %b want 000", tag, {stall, mem_req, q_RegWrite}); end
    tick;
    nChecks++;
    if (qAll !== {1'b1, 1'b1, 4'd7, rdata, addr}) begin nFails++; $display("FAIL %s_q got %h want %h", tag, qAll, {1'b1, 1'b1, 4'd7, rdata, addr}); end
    clearInputs;
  endtask
  task automatic test_load;
    run_load(3, 16'h0040, 16'hBEEF, 4, "load");
  endtask
  task automatic test_ack_first;
    run_load(1, 16'h0080, 16'hCAFE, 2, "ackfirst");
  endtask
  task automatic test_store_fwd;
    logic [3:0] rtA [4] = '{4'd3, 4'd3, 4'd0, 4'd3};
    logic [3:0] wbRdA [4] = '{4'd3, 4'd0, 4'd0, 4'd3};
    logic wbWeA [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] expA [4] = '{16'h2222, 16'h1111, 16'h1111, 16'h1111};
    for (int i = 0; i < 4; i++) begin
      d_MemWrite = 1'b1;
      d_RegRt = rtA[i];
      d_RegRtVal = 16'h1111;
      d_alu_data = 16'h0100;
      wb_RegWrite = wbWeA[i];
      wb_RegRd = wbRdA[i];
      wb_data = 16'h2222;
      tick;
      wb_data = 16'h3333;
      #1;
      nChecks++;
      if (mAll !== {1'b1, 1'b1, 16'h0100, expA[i]})
        begin nFails++; $display("FAIL store_fwd%0d got %h want %h", i, mAll, {1'b1, 1'b1, 16'h0100, expA[i]}); end
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      tick;
      clearInputs;
    end
  endtask
  task automatic test_reset_wait;
    d_MemRead = 1'b1;
    d_RegWrite = 1'b1;
    d_alu_data = 16'h0200;
    tick;
    nChecks++;
    if (mem_req !== 1'b1) begin nFails++; $display("FAIL rstwait_req got %b want 1", mem_req); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    clearInputs;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #1;
    nChecks++;
    if ({stall, mAll} !== 35'd0) begin nFails++; $display("FAIL rstwait_mem got %h want 0", {stall, mAll}); end
    nChecks++;
    if (qAll !== 38'd0) begin nFails++; $display("FAIL rstwait_q got %h want 0", qAll); end
    tick;
    mem_ack = 1'b0;
    nChecks++;
    if ({stall, mem_req, qAll} !== 40'd0) begin nFails++; $display("FAIL rstwait_late_ack got %h want 0", {stall, mem_req, qAll}); end
  endtask
  task automatic test_random;
    logic [37:0] expQ;
    logic [33:0] expM;
    logic [15:0] rdata;
    logic isMem;
    int lat;
    expQ = '0;
    rdata = '0;
    for (int i = 0; i < 40; i++) begin
      isMem = $urandom_range(0, 1) == 1;
      d_RegWrite = 1'($urandom);
      d_MemtoReg = 1'($urandom);
      d_RegRd = 4'($urandom);
      d_RegRt = 4'($urandom_range(0, 3));
      d_RegRtVal = 16'($urandom);
      d_alu_data = 16'($urandom);
      wb_RegWrite = 1'($urandom);
      wb_RegRd = 4'($urandom_range(0, 3));
      wb_data = 16'($urandom);
      {d_MemRead, d_MemWrite} = isMem ? 2'($urandom_range(1, 3)) : 2'b00;
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      #1;
      nChecks++;
      if (stall !== isMem) begin nFails++; $display("FAIL rand%0d_stall got %b want %b", i, stall, isMem); end
      if (!isMem) begin
        tick;
        expQ = {d_RegWrite, d_MemtoReg, d_RegRd, 16'h0000, d_alu_data};
      end else begin
        expM = {1'b1, d_MemWrite, d_alu_data,
                (wb_RegWrite && wb_RegRd == d_RegRt && wb_RegRd != 4'd0) ? wb_data : d_RegRtVal};
        lat = $urandom_range(1, 4);
        tick;
        for (int k = 1; k <= lat; k++) begin
          wb_data = 16'($urandom);
          wb_RegRd = 4'($urandom);
          mem_ack = (k == lat);
          mem_rdata = 16'($urandom);
          if (k == lat) rdata = mem_rdata;
          #1;
          nChecks++;
          if ({stall, mAll} !== {1'b1, expM}) begin nFails++; $display("FAIL rand%0d_wait got %h want %h", i, {stall, mAll}, {1'b1, expM}); end
          nChecks++;
          if (qAll !== {2'b00, expQ[35:0]}) begin nFails++; $display("FAIL rand%0d_bubble got %h want %h", i, qAll, {2'b00, expQ[35:0]}); end
          tick;
        end
        mem_ack = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        nChecks++;
        if ({stall, mem_req} !== 2'b00) begin nFails++; $display("FAIL rand%0d_done got %b want 00", i, {stall, mem_req}); end
        tick;
        expQ = {d_RegWrite, d_MemtoReg, d_RegRd, rdata, d_alu_data};
      end
      nChecks++;
      if (qAll !== expQ) begin nFails++; $display("FAIL rand%0d_q got %h want %h", i, qAll, expQ); end
    end
    clearInputs;
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store_fwd;
    test_ack_first;
    test_reset_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
